mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single data-memory port shared by the load path and the store-commit path of the out-of-order core. It accepts one request at a time over valid/ready handshakes, with loads normally prioritised and stores protected from starvation. It drives the synchronous data memory, formats byte and word accesses (LB/LW, SB/SW), and returns tagged load data to the load path.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Sequences the single data-memory port shared by the load path and the
// store-commit path. One access is outstanding at a time. Loads win by
// default, a store to the same word as a waiting load goes first, and when
// MEM_ARB_STARVE_EN is defined a waiting store is forced through after
// STARVE_MAX consecutive load grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int TAG_W      = 6,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic              ld_req_byte,
    input  logic [TAG_W-1:0]  ld_req_tag,
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [31:0]       st_req_data,
    input  logic              st_req_byte,
    output logic              ld_resp_valid,
    output logic [TAG_W-1:0]  ld_resp_tag,
    output logic [31:0]       ld_resp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] LWAIT = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] lat_cnt_reg;
    logic             is_load_reg;
    logic             byte_reg;
    logic [1:0]       lane_reg;
    logic [TAG_W-1:0] tag_reg;

    logic        same_word;
    logic        starve_hit;
    logic        grant_st;
    logic        grant_ld;
    logic        ld_hs;
    logic        st_hs;
    logic [7:0]  rd_byte;
    logic [31:0] rd_fmt;

    assign same_word = (ld_req_addr[ADDR_W-1:2] == st_req_addr[ADDR_W-1:2]);

`ifdef MEM_ARB_STARVE_EN
    localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    logic [SC_W-1:0] starve_cnt_reg;

    assign starve_hit = (starve_cnt_reg == SC_W'(STARVE_MAX));

    // Count load grants taken while a store is waiting; a store grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (st_hs) begin
            starve_cnt_reg <= '0;
        end else if (ld_hs && st_req_valid && !starve_hit) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end
`else
    // No starvation counter in this build: strict load priority apart from
    // the same-word rule. The compare is constant false for any legal STARVE_MAX.
    assign starve_hit = (STARVE_MAX < 0);
`endif

    // Grant decision: same-word conflict or starvation favours the store.
    always_comb begin
        grant_st = st_req_valid && (!ld_req_valid || same_word || starve_hit);
        grant_ld = ld_req_valid && !grant_st;
    end

    // Readies only in IDLE, and held low while reset is asserted.
    assign ld_req_ready = rst_n && (state_reg == IDLE) && grant_ld;
    assign st_req_ready = rst_n && (state_reg == IDLE) && grant_st;
    assign ld_hs        = ld_req_valid && ld_req_ready;
    assign st_hs        = st_req_valid && st_req_ready;

    // Load result formatting: pick the addressed lane and sign-extend for LB.
    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (lane_reg)
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            2'd3:    rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_fmt = byte_reg ? {{24{rd_byte[7]}}, rd_byte} : mem_rdata;
    end

    // Access sequencer: capture request, drive one memory cycle, wait, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lat_cnt_reg   <= '0;
            is_load_reg   <= 1'b0;
            byte_reg      <= 1'b0;
            lane_reg      <= 2'd0;
            tag_reg       <= '0;
            ld_resp_valid <= 1'b0;
            ld_resp_tag   <= '0;
            ld_resp_data  <= '0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= 4'b0000;
        end else begin
            // Response fields are a single-cycle pulse, zero otherwise.
            ld_resp_valid <= 1'b0;
            ld_resp_tag   <= '0;
            ld_resp_data  <= '0;
            case (state_reg)
                IDLE: begin
                    if (ld_hs) begin
                        state_reg   <= ISSUE;
                        is_load_reg <= 1'b1;
                        byte_reg    <= ld_req_byte;
                        lane_reg    <= ld_req_addr[1:0];
                        tag_reg     <= ld_req_tag;
                        mem_en      <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= {ld_req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata   <= '0;
                        mem_wmask   <= 4'b0000;
                    end else if (st_hs) begin
                        state_reg   <= ISSUE;
                        is_load_reg <= 1'b0;
                        mem_en      <= 1'b1;
                        mem_we      <= 1'b1;
                        mem_addr    <= {st_req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata   <= st_req_byte ? {4{st_req_data[7:0]}} : st_req_data;
                        mem_wmask   <= st_req_byte ? (4'b0001 << st_req_addr[1:0]) : 4'b1111;
                    end
                end
                ISSUE: begin
                    mem_en      <= 1'b0;
                    mem_we      <= 1'b0;
                    mem_addr    <= '0;
                    mem_wdata   <= '0;
                    mem_wmask   <= 4'b0000;
                    lat_cnt_reg <= CNT_W'(MEM_LAT - 1);
                    state_reg   <= is_load_reg ? LWAIT : IDLE;
                end
                LWAIT: begin
                    if (lat_cnt_reg == '0) begin
                        state_reg     <= RESP;
                        ld_resp_valid <= 1'b1;
                        ld_resp_tag   <= tag_reg;
                        ld_resp_data  <= rd_fmt;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized phase,
// checked by a scoreboard against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int TAG_W      = 6;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              ld_req_valid = 1'b0;
    logic              ld_req_ready;
    logic [ADDR_W-1:0] ld_req_addr = '0;
    logic              ld_req_byte = 1'b0;
    logic [TAG_W-1:0]  ld_req_tag = '0;
    logic              st_req_valid = 1'b0;
    logic              st_req_ready;
    logic [ADDR_W-1:0] st_req_addr = '0;
    logic [31:0]       st_req_data = '0;
    logic              st_req_byte = 1'b0;
    logic              ld_resp_valid;
    logic [TAG_W-1:0]  ld_resp_tag;
    logic [31:0]       ld_resp_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_req_addr(ld_req_addr), .ld_req_byte(ld_req_byte), .ld_req_tag(ld_req_tag),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
        .st_req_addr(st_req_addr), .st_req_data(st_req_data), .st_req_byte(st_req_byte),
        .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag), .ld_resp_data(ld_resp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int               cyc;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } resp_exp_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];
    bit        grants[$];      // 1 = store grant, 0 = load grant

    logic [31:0] ref_mem[int];  // what the memory must contain
    logic [31:0] phys_mem[int]; // what the DUT actually wrote

    int next_free = 0;  // first cycle in which the port may accept again
    int starve = 0;     // consecutive load grants while a store waited
    bit ld_taken = 1'b0;
    bit st_taken = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int w);
        return (w * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction

    function automatic logic [31:0] phys_rd(input int w);
        if (phys_mem.exists(w)) return phys_mem[w];
        return init_word(w);
    endfunction

    // One clock of the reference model: check readies, model any handshake.
    task automatic step();
        logic        idle;
        logic        st_pri;
        logic        exp_ld;
        logic        exp_st;
        logic [31:0] w;
        logic [31:0] b;
        int          sh;
        mem_exp_t    me;
        resp_exp_t   re;
        @(negedge clk);
        ld_taken = 1'b0;
        st_taken = 1'b0;
        idle   = (cyc >= next_free);
        st_pri = st_req_valid && (!ld_req_valid ||
                 ((ld_req_addr >> 2) == (st_req_addr >> 2)) ||
                 (STARVE_ON && starve >= STARVE_MAX));
        exp_st = idle && st_pri;
        exp_ld = idle && ld_req_valid && !st_pri;
        chk("ld_req_ready", ld_req_ready, exp_ld);
        chk("st_req_ready", st_req_ready, exp_st);
        sh = 8 * int'(ld_req_addr % 4);
        if (exp_ld) begin
            me.cyc = cyc + 1; me.addr = ld_req_addr & ~32'd3; me.we = 1'b0;
            me.mask = 4'b0000; me.wdata = '0;
            mem_q.push_back(me);
            w = ref_rd(int'(ld_req_addr >> 2));
            b = (w >> sh) & 32'hFF;
            re.cyc  = cyc + 2 + MEM_LAT;
            re.tag  = ld_req_tag;
            re.data = ld_req_byte ? ((b >= 32'd128) ? b - 32'd256 : b) : w;
            resp_q.push_back(re);
            next_free = cyc + 3 + MEM_LAT;
            if (st_req_valid && starve < STARVE_MAX) starve++;
            grants.push_back(1'b0);
            ld_taken = 1'b1;
        end else if (exp_st) begin
            sh = 8 * int'(st_req_addr % 4);
            me.cyc  = cyc + 1;
            me.addr = st_req_addr & ~32'd3;
            me.we   = 1'b1;
            w = ref_rd(int'(st_req_addr >> 2));
            if (st_req_byte) begin
                me.mask  = 4'(1 << (sh / 8));
                me.wdata = (st_req_data & 32'hFF) * 32'h01010101;
                w = (w & ~(32'hFF << sh)) | ((st_req_data & 32'hFF) << sh);
            end else begin
                me.mask  = 4'b1111;
                me.wdata = st_req_data;
                w = st_req_data;
            end
            ref_mem[int'(st_req_addr >> 2)] = w;
            mem_q.push_back(me);
            next_free = cyc + 2;
            starve = 0;
            grants.push_back(1'b1);
            st_taken = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: memory model plus scoreboard pops for memory accesses and responses.
    int          rd_cycle = -1;
    int          rd_word = 0;
    mem_exp_t    mon_me;
    resp_exp_t   mon_re;
    logic [31:0] mon_w;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cycle = -1;
        end else begin
            if (rd_cycle == cyc) mem_rdata = phys_rd(rd_word);
            else mem_rdata = $urandom;
            if (mem_en) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_en", mem_en, 1'b0);
                end else begin
                    mon_me = mem_q.pop_front();
                    chk("mem_cycle", cyc, mon_me.cyc);
                    chk("mem_addr", mem_addr, mon_me.addr);
                    chk("mem_we", mem_we, mon_me.we);
                    chk("mem_wmask", mem_wmask, mon_me.mask);
                    if (mon_me.we) begin
                        chk("mem_wdata", mem_wdata, mon_me.wdata);
                        mon_w = phys_rd(int'(mem_addr >> 2));
                        for (int i = 0; i < 4; i++)
                            if (mem_wmask[i]) mon_w[8*i +: 8] = mem_wdata[8*i +: 8];
                        phys_mem[int'(mem_addr >> 2)] = mon_w;
                    end else begin
                        rd_cycle = cyc + MEM_LAT;
                        rd_word  = int'(mem_addr >> 2);
                    end
                end
            end else begin
                chk("idle_we_wmask", {mem_we, mem_wmask}, 5'd0);
            end
            if (ld_resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_ld_resp", ld_resp_valid, 1'b0);
                end else begin
                    mon_re = resp_q.pop_front();
                    $display("[TB] cycle %0d load resp tag %0d data 0x%08h", cyc, ld_resp_tag, ld_resp_data);
                    chk("resp_cycle", cyc, mon_re.cyc);
                    chk("resp_tag", ld_resp_tag, mon_re.tag);
                    chk("resp_data", ld_resp_data, mon_re.data);
                end
            end else begin
                chk("idle_resp_fields", {ld_resp_tag, ld_resp_data}, '0);
            end
        end
    end

    task automatic send_ld(input logic [31:0] a, input logic by, input logic [TAG_W-1:0] t);
        int n = 0;
        ld_req_valid = 1'b1; ld_req_addr = a; ld_req_byte = by; ld_req_tag = t;
        ld_taken = 1'b0;
        while (!ld_taken && n < 50) begin step(); n++; end
        ld_req_valid = 1'b0;
        tests++;
        if (!ld_taken) begin fails++; $display("FAIL ld_grant_timeout: no grant in %0d cycles", n); end
        else $display("[TB] cycle %0d load issued addr 0x%08h byte %0d tag %0d", cyc, a, by, t);
    endtask

    task automatic send_st(input logic [31:0] a, input logic [31:0] d, input logic by);
        int n = 0;
        st_req_valid = 1'b1; st_req_addr = a; st_req_data = d; st_req_byte = by;
        st_taken = 1'b0;
        while (!st_taken && n < 50) begin step(); n++; end
        st_req_valid = 1'b0;
        tests++;
        if (!st_taken) begin fails++; $display("FAIL st_grant_timeout: no grant in %0d cycles", n); end
        else $display("[TB] cycle %0d store issued addr 0x%08h data 0x%08h byte %0d", cyc, a, d, by);
    endtask

    task automatic drain();
        int n = 0;
        while ((mem_q.size() != 0 || resp_q.size() != 0) && n < 60) begin step(); n++; end
        tests++;
        if (mem_q.size() != 0 || resp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d mem and %0d resp expectations outstanding", mem_q.size(), resp_q.size());
            mem_q.delete();
            resp_q.delete();
        end
        step();
        step();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ld_req_ready"}, ld_req_ready, 1'b0);
        chk({tag, "_st_req_ready"}, st_req_ready, 1'b0);
        chk({tag, "_ld_resp"}, {ld_resp_valid, ld_resp_tag, ld_resp_data}, '0);
        chk({tag, "_mem_ctl"}, {mem_en, mem_we, mem_wmask}, '0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ld_done;
        bit st_done;
        int n;

        // Reset, with requests pending so ready gating is exercised.
        #2;
        rst_n = 1'b0;
        ld_req_valid = 1'b1; st_req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        ld_req_valid = 1'b0; st_req_valid = 1'b0;
        rst_n = 1'b1;
        next_free = 0; starve = 0;
        repeat (2) step();

        // Single LW.
        ref_mem[32'h104 >> 2] = 32'hDEADBEEF; phys_mem[32'h104 >> 2] = 32'hDEADBEEF;
        send_ld(32'h104, 1'b0, 6'd5);
        drain();

        // LB sign extension, upper and lower lane.
        ref_mem[32'h200 >> 2] = 32'h80112233; phys_mem[32'h200 >> 2] = 32'h80112233;
        send_ld(32'h203, 1'b1, 6'd6);
        drain();
        send_ld(32'h200, 1'b1, 6'd7);
        drain();

        // SB followed immediately by SW (ready returns two cycles after handshake),
        // then read the word back.
        send_st(32'h302, 32'h000000A5, 1'b1);
        send_st(32'h500, 32'h12345678, 1'b0);
        drain();
        send_ld(32'h300, 1'b0, 6'd8);
        send_ld(32'h500, 1'b0, 6'd9);
        drain();

        // Same-word conflict: load 0x404 and SW 0x406 offered together.
        grants.delete();
        ld_req_valid = 1'b1; ld_req_addr = 32'h404; ld_req_byte = 1'b0; ld_req_tag = 6'd10;
        st_req_valid = 1'b1; st_req_addr = 32'h406; st_req_data = 32'hCAFEF00D; st_req_byte = 1'b0;
        ld_done = 1'b0; st_done = 1'b0; n = 0;
        while (!(ld_done && st_done) && n < 60) begin
            step();
            if (ld_taken) begin ld_done = 1'b1; ld_req_valid = 1'b0; end
            if (st_taken) begin st_done = 1'b1; st_req_valid = 1'b0; end
            n++;
        end
        ld_req_valid = 1'b0; st_req_valid = 1'b0;
        chk("same_word_grant_count", grants.size(), 2);
        if (grants.size() > 0) chk("same_word_first_is_store", grants[0], 1'b1);
        drain();

        // Arbitration: both paths held valid on distinct words.
        grants.delete();
        ld_req_valid = 1'b1; ld_req_addr = 32'h600; ld_req_byte = 1'b0; ld_req_tag = 6'd20;
        st_req_valid = 1'b1; st_req_addr = 32'h700; st_req_data = 32'h0BADC0DE; st_req_byte = 1'b0;
        for (int i = 0; i < 300 && grants.size() < 10; i++) begin
            step();
            if (ld_taken) begin
                ld_req_addr = 32'h600 + 32'(4 * grants.size());
                ld_req_tag  = ld_req_tag + 6'd1;
            end
            if (st_taken) begin
                st_req_addr = 32'h700 + 32'(4 * grants.size());
                st_req_data = $urandom;
            end
        end
        ld_req_valid = 1'b0; st_req_valid = 1'b0;
        chk("arb_grant_count", grants.size(), 10);
        for (int i = 0; i < 10 && i < grants.size(); i++)
            chk($sformatf("arb_grant_%0d", i), grants[i], STARVE_ON ? ((i % 5) == 4) : 1'b0);
        drain();

        // Reset while a load waits on memory latency.
        ld_req_valid = 1'b1; ld_req_addr = 32'h104; ld_req_byte = 1'b0; ld_req_tag = 6'd30;
        ld_taken = 1'b0; n = 0;
        while (!ld_taken && n < 50) begin step(); n++; end
        ld_req_valid = 1'b0;
        chk("rst_mid_load_granted", ld_taken, 1'b1);
        @(posedge clk);
        #2;
        ld_req_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst_mid");
        resp_q.delete();
        ld_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        next_free = 0; starve = 0;
        repeat (8) step();
        send_ld(32'h104, 1'b0, 6'd31);
        drain();

        // Randomized mix over a small address window to provoke conflicts.
        for (int i = 0; i < 400; i++) begin
            if (!ld_req_valid && $urandom_range(0, 2) == 0) begin
                ld_req_valid = 1'b1;
                ld_req_addr  = 32'h100 + 32'($urandom_range(0, 31));
                ld_req_byte  = 1'($urandom_range(0, 1));
                ld_req_tag   = TAG_W'($urandom);
            end
            if (!st_req_valid && $urandom_range(0, 2) == 0) begin
                st_req_valid = 1'b1;
                st_req_addr  = 32'h100 + 32'($urandom_range(0, 31));
                st_req_data  = $urandom;
                st_req_byte  = 1'($urandom_range(0, 1));
            end
            step();
            if (ld_taken) ld_req_valid = 1'b0;
            if (st_taken) st_req_valid = 1'b0;
        end
        ld_req_valid = 1'b0; st_req_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
